// File: rtl/seg_pkg.sv
// Shared constants for BCD digits and seven-segment patterns.
// Patterns are active-high, with bit order g..a.
package seg_pkg;

   localparam int unsigned BcdW = 4;
   localparam int unsigned SegW = 8;

   localparam logic [6:0] Seg0 = 7'h3F;
   localparam logic [6:0] Seg1 = 7'h06;
   localparam logic [6:0] Seg2 = 7'h5B;
   localparam logic [6:0] Seg3 = 7'h4F;
   localparam logic [6:0] Seg4 = 7'h66;
   localparam logic [6:0] Seg5 = 7'h6D;
   localparam logic [6:0] Seg6 = 7'h7D;
   localparam logic [6:0] Seg7 = 7'h07;
   localparam logic [6:0] Seg8 = 7'h7F;
   localparam logic [6:0] Seg9 = 7'h6F;

   function automatic logic [6:0] seg_pattern(input logic [BcdW-1:0] d);
      case (d)
         4'd0:    return Seg0;
         4'd1:    return Seg1;
         4'd2:    return Seg2;
         4'd3:    return Seg3;
         4'd4:    return Seg4;
         4'd5:    return Seg5;
         4'd6:    return Seg6;
         4'd7:    return Seg7;
         4'd8:    return Seg8;
         4'd9:    return Seg9;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [BcdW-1:0] bcd_clamp(input logic [BcdW-1:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/bcd7seg.sv
// One BCD digit to eight segment bits (dp in bit 7, always off).
// The selected polarity applies to every bit, dp included.
module bcd7seg
   import seg_pkg::*;
(
   input  logic [BcdW-1:0] digit_i,
   input  logic            active_low_i,
   output logic [SegW-1:0] seg_o
);

   logic [SegW-1:0] seg_hi;

   assign seg_hi = {1'b0, seg_pattern(digit_i)};
   assign seg_o  = active_low_i ? ~seg_hi : seg_hi;

endmodule

// File: rtl/bcd_seg_counter.sv
// Prescaled up/down BCD counter with wrap/saturate limits.
// It also provides a per-digit seven-segment decode.
module bcd_seg_counter
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS         = 2,
   parameter int unsigned TICK_DIV       = 50000000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     en,
   input  logic                     up,
   input  logic                     wrap_en,
   input  logic                     clr,
   input  logic                     load,
   input  logic [BcdW*DIGITS-1:0]   load_val,
   output logic [BcdW*DIGITS-1:0]   bcd,
   output logic [SegW*DIGITS-1:0]   seg,
   output logic                     tick,
   output logic                     wrap
);

   localparam int unsigned BcdTotW = BcdW * DIGITS;
   localparam int unsigned PresW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);

   logic [PresW-1:0]   pres_q, pres_d;
   logic [BcdTotW-1:0] bcd_q, bcd_d;
   logic [BcdTotW-1:0] bcd_inc, bcd_dec, bcd_ld;
   logic               wrap_q, wrap_d;
   logic               tick_int;
   logic               carry, borrow;

   assign tick_int = en & (pres_q == PresMax);
   // With TICK_DIV=1, pres_q is always at terminal count, so tick must be gated by reset.
   assign tick     = tick_int & resetn;

   always_comb begin
      pres_d = pres_q;
      if (clr || tick_int) begin
         pres_d = '0;
      end else if (en) begin
         pres_d = pres_q + PresW'(1);
      end
   end

   // carry/borrow leave the loop set only when every digit was 9 (or every digit was 0).
   always_comb begin
      carry   = 1'b1;
      borrow  = 1'b1;
      bcd_inc = bcd_q;
      bcd_dec = bcd_q;
      bcd_ld  = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (carry) begin
            if (bcd_q[i*BcdW +: BcdW] == 4'd9) begin
               bcd_inc[i*BcdW +: BcdW] = 4'd0;
            end else begin
               bcd_inc[i*BcdW +: BcdW] = bcd_q[i*BcdW +: BcdW] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (bcd_q[i*BcdW +: BcdW] == 4'd0) begin
               bcd_dec[i*BcdW +: BcdW] = 4'd9;
            end else begin
               bcd_dec[i*BcdW +: BcdW] = bcd_q[i*BcdW +: BcdW] - 4'd1;
               borrow = 1'b0;
            end
         end
         bcd_ld[i*BcdW +: BcdW] = bcd_clamp(load_val[i*BcdW +: BcdW]);
      end
   end

   always_comb begin
      bcd_d  = bcd_q;
      wrap_d = 1'b0;
      if (clr) begin
         bcd_d = '0;
      end else if (load) begin
         bcd_d = bcd_ld;
      end else if (tick_int) begin
         if (up) begin
            if (!carry || wrap_en) bcd_d = bcd_inc;
            wrap_d = carry & wrap_en;
         end else begin
            if (!borrow || wrap_en) bcd_d = bcd_dec;
            wrap_d = borrow & wrap_en;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pres_q <= '0;
         bcd_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         pres_q <= pres_d;
         bcd_q  <= bcd_d;
         wrap_q <= wrap_d;
      end
   end

   assign bcd  = bcd_q;
   assign wrap = wrap_q;

   for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_digit
      bcd7seg u_bcd7seg (
         .digit_i      (bcd_q[g*BcdW +: BcdW]),
         .active_low_i (SEG_ACTIVE_LOW),
         .seg_o        (seg[g*SegW +: SegW])
      );
   end

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Scoreboard bench for bcd_seg_counter (2 digits, divide-by-4, active-low segments).
// A decimal reference model predicts bcd/wrap and is compared after each edge.
module tb_bcd_seg_counter;

   localparam int unsigned Digits  = 2;
   localparam int unsigned TickDiv = 4;

   typedef struct packed {
      logic [7:0] bcd;
      logic       wrap;
   } exp_t;

   logic        clk, resetn, en, up, wrap_en, clr, load;
   logic [7:0]  load_val;
   logic [7:0]  bcd;
   logic [15:0] seg;
   logic        tick, wrap;

   int   n_checks, n_errors;
   int   m_val, m_presc;
   int   obs_ticks, obs_wraps;
   bit   last_tick;
   exp_t sb_q[$];

   bcd_seg_counter #(
      .DIGITS         (Digits),
      .TICK_DIV       (TickDiv),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .en       (en),
      .up       (up),
      .wrap_en  (wrap_en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .bcd      (bcd),
      .seg      (seg),
      .tick     (tick),
      .wrap     (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int clamp(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   function automatic logic [7:0] seg_lo(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'd0: p = 8'h3F;
         4'd1: p = 8'h06;
         4'd2: p = 8'h5B;
         4'd3: p = 8'h4F;
         4'd4: p = 8'h66;
         4'd5: p = 8'h6D;
         4'd6: p = 8'h7D;
         4'd7: p = 8'h07;
         4'd8: p = 8'h7F;
         4'd9: p = 8'h6F;
         default: p = 8'h00;
      endcase
      return ~p;
   endfunction

   function automatic logic [15:0] exp_seg(input logic [7:0] b);
      return {seg_lo(b[7:4]), seg_lo(b[3:0])};
   endfunction

   // One clock: check tick before the edge, push the prediction, pop and compare after it.
   task automatic cycle();
      bit   exp_tick;
      int   nv;
      bit   nw;
      exp_t e;
      #1;
      exp_tick  = en && (m_presc == int'(TickDiv) - 1);
      last_tick = tick;
      if (tick) obs_ticks++;
      check_val("tick", tick, exp_tick);
      nv = m_val;
      nw = 1'b0;
      if (clr) begin
         nv = 0;
      end else if (load) begin
         nv = clamp(load_val[7:4]) * 10 + clamp(load_val[3:0]);
      end else if (exp_tick) begin
         if (up) begin
            if (m_val == 99) begin
               if (wrap_en) begin nv = 0; nw = 1'b1; end
            end else nv = m_val + 1;
         end else begin
            if (m_val == 0) begin
               if (wrap_en) begin nv = 99; nw = 1'b1; end
            end else nv = m_val - 1;
         end
      end
      if (clr || exp_tick) m_presc = 0;
      else if (en) m_presc++;
      m_val  = nv;
      e.bcd  = to_bcd(nv);
      e.wrap = nw;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (wrap) obs_wraps++;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_val("bcd", bcd, e.bcd);
         check_val("wrap", wrap, e.wrap);
         check_val("seg", seg, exp_seg(e.bcd));
      end
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      #1;
      check_val("rst_bcd", bcd, 8'h00);
      check_val("rst_seg", seg, 16'hC0C0);
      check_val("rst_tick", tick, 1'b0);
      check_val("rst_wrap", wrap, 1'b0);
      m_val   = 0;
      m_presc = 0;
      sb_q.delete();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic do_load(input logic [7:0] v);
      en       = 1'b0;
      load     = 1'b1;
      load_val = v;
      cycle();
      load     = 1'b0;
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_errors = 0;
      resetn = 1'b0; en = 1'b0; up = 1'b1; wrap_en = 1'b1;
      clr = 1'b0; load = 1'b0; load_val = 8'h00;
      #2;
      apply_reset();

      // Steady counting: 40 en-cycles from a cleared prescaler gives 10 ticks.
      clr = 1'b1; cycle(); clr = 1'b0;
      en = 1'b1; up = 1'b1; wrap_en = 1'b1;
      obs_ticks = 0;
      repeat (40) cycle();
      check_val("ticks40", obs_ticks, 10);
      check_val("bcd_after40", bcd, 8'h10);

      // Upper limit, wrap then saturate.
      do_load(8'h99);
      en = 1'b1; up = 1'b1; wrap_en = 1'b1; obs_wraps = 0;
      repeat (TickDiv) cycle();
      check_val("up_wrap_bcd", bcd, 8'h00);
      check_val("up_wrap_cnt", obs_wraps, 1);
      do_load(8'h99);
      en = 1'b1; wrap_en = 1'b0; obs_wraps = 0;
      repeat (TickDiv) cycle();
      check_val("up_sat_bcd", bcd, 8'h99);
      check_val("up_sat_cnt", obs_wraps, 0);

      // Lower limit, wrap then saturate.
      do_load(8'h00);
      en = 1'b1; up = 1'b0; wrap_en = 1'b1; obs_wraps = 0;
      repeat (TickDiv) cycle();
      check_val("dn_wrap_bcd", bcd, 8'h99);
      check_val("dn_wrap_cnt", obs_wraps, 1);
      do_load(8'h00);
      en = 1'b1; wrap_en = 1'b0; obs_wraps = 0;
      repeat (TickDiv) cycle();
      check_val("dn_sat_bcd", bcd, 8'h00);
      check_val("dn_sat_cnt", obs_wraps, 0);

      // Load clamping and priority.
      do_load(8'hA7);
      check_val("load_a7", bcd, 8'h97);
      do_load(8'h3C);
      check_val("load_3c", bcd, 8'h39);
      clr = 1'b1; load = 1'b1; load_val = 8'h55; cycle();
      clr = 1'b0; load = 1'b0;
      check_val("clr_over_load", bcd, 8'h00);
      en = 1'b1; up = 1'b1; wrap_en = 1'b1;
      n = 0;
      while (m_presc != int'(TickDiv) - 1 && n < 8) begin
         cycle();
         n++;
      end
      check_val("presc_reach", n < 8, 1'b1);
      load = 1'b1; load_val = 8'h61; cycle(); load = 1'b0;
      check_val("load_tick_tick", last_tick, 1'b1);
      check_val("load_over_tick", bcd, 8'h61);

      // Random mix of enable, direction, wrap mode, loads and clears.
      for (int i = 0; i < 120; i++) begin
         en       = ($urandom_range(0, 3) != 0);
         up       = $urandom_range(0, 1) == 1;
         wrap_en  = $urandom_range(0, 1) == 1;
         load     = ($urandom_range(0, 11) == 0);
         clr      = ($urandom_range(0, 29) == 0);
         load_val = 8'($urandom);
         cycle();
      end
      load = 1'b0; clr = 1'b0;

      // Asynchronous reset in the middle of a prescaler count.
      clr = 1'b1; en = 1'b0; cycle(); clr = 1'b0;
      do_load(8'h42);
      en = 1'b1; up = 1'b1;
      repeat (2) cycle();
      check_val("pre_rst_bcd", bcd, 8'h42);
      apply_reset();
      n = 0;
      last_tick = 1'b0;
      while (!last_tick && n < 10) begin
         cycle();
         n++;
      end
      check_val("first_tick_after_rst", n, TickDiv);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bcd_seg_counter.md
BCD_SEG_COUNTER -- requirements
Module: bcd_seg_counter

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD digits (legal range 1..8).
REQ-002 Parameter TICK_DIV, default 50000000, clk cycles per count tick (legal minimum 1).
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, 1 = segment outputs driven active-low.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port resetn  input  1  reset, asynchronous, active-low.
REQ-006 Port en  input  1  1 = prescaler runs and ticks advance the count.
REQ-007 Port up  input  1  1 = count up, 0 = count down.
REQ-008 Port wrap_en  input  1  1 = wrap at the range limits, 0 = saturate.
REQ-009 Port clr  input  1  synchronous clear of count and prescaler.
REQ-010 Port load  input  1  synchronous load of load_val.
REQ-011 Port load_val  input  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
REQ-012 Port bcd  output  4*DIGITS  current count, registered BCD.
REQ-013 Port seg  output  8*DIGITS  per-digit segments; per byte, [6:0] = g..a and [7] = dp.
REQ-014 Port tick  output  1  one-cycle pulse on each prescaler terminal count.
REQ-015 Port wrap  output  1  one-cycle pulse when the count wraps.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 only while en=1 and SHALL hold its value while en=0.
REQ-017 tick SHALL be 1 in exactly the cycle the prescaler equals TICK_DIV-1 with en=1; the prescaler then returns to 0.
REQ-018 When TICK_DIV=1, tick SHALL be 1 on every cycle in which en=1.
REQ-019 Update priority SHALL be clr > load > tick; only the highest-priority event present in a cycle takes effect.
REQ-020 On clr, bcd SHALL become 0 and the prescaler SHALL become 0 on the next edge; wrap SHALL stay 0.
REQ-021 On load, bcd SHALL take load_val on the next edge; any digit greater than 9 SHALL be clamped to 9; the prescaler is unaffected.
REQ-022 On tick with up=1, bcd SHALL increment by 1 in decimal, with carry rippling across digits within the same cycle.
REQ-023 On tick with up=0, bcd SHALL decrement by 1 in decimal, with borrow rippling across digits within the same cycle.
REQ-024 Incrementing from 10^DIGITS-1: if wrap_en=1, bcd SHALL become 0 and wrap SHALL pulse; if wrap_en=0, bcd SHALL hold and wrap SHALL stay 0.
REQ-025 Decrementing from 0: if wrap_en=1, bcd SHALL become 10^DIGITS-1 and wrap SHALL pulse; if wrap_en=0, bcd SHALL hold and wrap SHALL stay 0.
REQ-026 The count update SHALL be visible on bcd one cycle after tick; wrap SHALL be registered and aligned with that bcd change.
REQ-027 seg SHALL be a combinational decode of the bcd register, so there is no extra latency.
REQ-028 Active-high segment patterns SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex), with dp off.
REQ-029 When SEG_ACTIVE_LOW=1, every seg bit, dp included, SHALL be the inverse of the active-high pattern.
REQ-030 Changes to up or wrap_en SHALL take effect on the next tick only.

Reset
REQ-031 While resetn=0, bcd, prescaler, tick and wrap SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 While resetn=0, seg SHALL show digit 0 on every digit.
REQ-033 An in-progress prescaler count SHALL be discarded by reset.
REQ-034 The first tick after resetn is released SHALL occur TICK_DIV en-cycles later.

Structure
REQ-035 The segment pattern constants and the BCD digit width (4) SHALL live in a shared package seg_pkg.
REQ-036 A single sub-module bcd7seg (one BCD digit plus polarity to 8 segment bits) SHALL be instantiated DIGITS times.
REQ-037 The prescaler and the BCD counter SHALL stay in the top of the module.

Verification (DIGITS=2, TICK_DIV=4, SEG_ACTIVE_LOW=1)
REQ-038 Reset: assert resetn=0 -> bcd=00 and both seg bytes = C0.
REQ-039 Counting: en=1, up=1, hold 40 cycles -> tick pulses every 4th cycle and bcd=10 after the 10th tick.
REQ-040 Up limit: load 99, up=1, wrap_en=1 -> next tick gives bcd=00 with a one-cycle wrap; repeat with wrap_en=0 -> bcd stays 99 and wrap=0.
REQ-041 Down limit: load 00, up=0, wrap_en=1 -> next tick gives bcd=99 with wrap=1; with wrap_en=0 -> bcd stays 00.
REQ-042 Load rules: load_val=A7 -> bcd=97; clr=1 and load=1 together -> bcd=00; load and tick in the same cycle -> loaded value wins.
REQ-043 Reset mid-operation: pull resetn low mid-prescaler at bcd=42 -> bcd=00 before the next edge; after release the first tick comes 4 en-cycles later.
